// File: rtl/vc_tag_array.sv
// Fully associative victim-cache tag store with registered lookup, insert and invalidate.
// Replacement is FIFO by default; define VC_TAG_LRU_EN for true LRU.
module vc_tag_array #(
  parameter int unsigned WAYS  = 8,
  parameter int unsigned TAG_W = 27,
  localparam int unsigned WAY_W = $clog2(WAYS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             lookup_valid_i,
  input  logic [TAG_W-1:0] lookup_tag_i,
  output logic             lookup_valid_o,
  output logic             lookup_hit_o,
  output logic [WAY_W-1:0] lookup_way_o,
  output logic             lookup_dirty_o,
  input  logic             ins_valid_i,
  output logic             ins_ready_o,
  input  logic [TAG_W-1:0] ins_tag_i,
  input  logic             ins_dirty_i,
  output logic [WAY_W-1:0] ins_way_o,
  output logic             evict_valid_o,
  output logic [TAG_W-1:0] evict_tag_o,
  output logic             evict_dirty_o,
  input  logic             inv_valid_i,
  input  logic [WAY_W-1:0] inv_way_i,
  output logic             full_o,
  output logic [WAY_W:0]   count_o
);

  logic [WAYS-1:0]  valid_q, valid_d, dirty_q, dirty_d;
  logic [TAG_W-1:0] tag_q [WAYS];
  logic [TAG_W-1:0] tag_d [WAYS];

  logic             lk_hit, ins_hit, free_found, ins_fire, ins_evict;
  logic [WAY_W-1:0] lk_way, ins_hit_way, free_way, ins_way, victim;
  logic [WAY_W:0]   cnt;

  logic             lk_valid_q, lk_hit_q, lk_dirty_q;
  logic [WAY_W-1:0] lk_way_q;
  logic             ev_valid_q, ev_dirty_q;
  logic [TAG_W-1:0] ev_tag_q;

  always_comb begin
    lk_hit      = 1'b0;
    lk_way      = '0;
    ins_hit     = 1'b0;
    ins_hit_way = '0;
    free_found  = 1'b0;
    free_way    = '0;
    cnt         = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w] && tag_q[w] == lookup_tag_i) begin
        lk_hit = 1'b1;
        lk_way = WAY_W'(w);
      end
      if (valid_q[w] && tag_q[w] == ins_tag_i) begin
        ins_hit     = 1'b1;
        ins_hit_way = WAY_W'(w);
      end
      if (!valid_q[w] && !free_found) begin
        free_found = 1'b1;
        free_way   = WAY_W'(w);
      end
      cnt = cnt + (WAY_W+1)'(valid_q[w]);
    end
  end

  // Invalidate owns the cycle; insert stalls behind it.
  always_comb begin
    ins_fire  = ins_valid_i && !inv_valid_i;
    ins_evict = 1'b0;
    ins_way   = victim;
    if (ins_hit) begin
      ins_way = ins_hit_way;
    end else if (free_found) begin
      ins_way = free_way;
    end else begin
      ins_evict = 1'b1;
    end
  end

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    tag_d   = tag_q;
    if (inv_valid_i) begin
      valid_d[inv_way_i] = 1'b0;
      dirty_d[inv_way_i] = 1'b0;
    end else if (ins_valid_i) begin
      valid_d[ins_way] = 1'b1;
      dirty_d[ins_way] = ins_dirty_i | (ins_hit & dirty_q[ins_way]);
      tag_d[ins_way]   = ins_tag_i;
    end
  end

`ifdef VC_TAG_LRU_EN
  logic [WAY_W-1:0] age_q  [WAYS];
  logic [WAY_W-1:0] age_lk [WAYS];
  logic [WAY_W-1:0] age_d  [WAYS];

  // Lookup touch is applied first; the victim is chosen from that intermediate state.
  always_comb begin
    age_lk = age_q;
    if (lookup_valid_i && lk_hit) begin
      for (int w = 0; w < WAYS; w++) begin
        if (WAY_W'(w) == lk_way) age_lk[w] = '0;
        else if (age_q[w] < age_q[lk_way]) age_lk[w] = age_q[w] + 1'b1;
      end
    end
    victim = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (age_lk[w] == WAY_W'(WAYS - 1)) victim = WAY_W'(w);
    end
  end

  always_comb begin
    age_d = age_lk;
    if (ins_fire) begin
      for (int w = 0; w < WAYS; w++) begin
        if (WAY_W'(w) == ins_way) age_d[w] = '0;
        else if (age_lk[w] < age_lk[ins_way]) age_d[w] = age_lk[w] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int w = 0; w < WAYS; w++) age_q[w] <= WAY_W'(w);
    end else begin
      age_q <= age_d;
    end
  end
`else
  logic [WAY_W-1:0] ptr_q, ptr_d;

  always_comb begin
    victim = ptr_q;
    ptr_d  = (ins_fire && ins_evict) ? ptr_q + 1'b1 : ptr_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q    <= '0;
      dirty_q    <= '0;
      lk_valid_q <= 1'b0;
      lk_hit_q   <= 1'b0;
      lk_way_q   <= '0;
      lk_dirty_q <= 1'b0;
      ev_valid_q <= 1'b0;
      ev_tag_q   <= '0;
      ev_dirty_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
      lk_valid_q <= lookup_valid_i;
      lk_hit_q   <= lookup_valid_i && lk_hit;
      lk_way_q   <= (lookup_valid_i && lk_hit) ? lk_way : '0;
      lk_dirty_q <= lookup_valid_i && lk_hit && dirty_q[lk_way];
      ev_valid_q <= ins_fire && ins_evict;
      ev_tag_q   <= (ins_fire && ins_evict) ? tag_q[ins_way] : '0;
      ev_dirty_q <= ins_fire && ins_evict && dirty_q[ins_way];
    end
  end

  // Tags need no reset: they are only observed through a set valid bit.
  always_ff @(posedge clk_i) begin
    tag_q <= tag_d;
  end

  assign lookup_valid_o = lk_valid_q;
  assign lookup_hit_o   = lk_hit_q;
  assign lookup_way_o   = lk_way_q;
  assign lookup_dirty_o = lk_dirty_q;
  assign ins_ready_o    = !inv_valid_i;
  assign ins_way_o      = ins_fire ? ins_way : '0;
  assign evict_valid_o  = ev_valid_q;
  assign evict_tag_o    = ev_tag_q;
  assign evict_dirty_o  = ev_dirty_q;
  assign full_o         = &valid_q;
  assign count_o        = cnt;

endmodule

// File: tb/tb_vc_tag_array.sv
// Randomised and directed bench for vc_tag_array against a recency-queue reference model.
// Follows VC_TAG_LRU_EN to pick LRU or FIFO expectations.
module tb_vc_tag_array;
  localparam int unsigned WAYS  = 8;
  localparam int unsigned TAG_W = 27;
  localparam int unsigned WAY_W = 3;

  logic             clk = 1'b0;
  logic             rst_i;
  logic             lookup_valid_i, lookup_valid_o, lookup_hit_o, lookup_dirty_o;
  logic [TAG_W-1:0] lookup_tag_i;
  logic [WAY_W-1:0] lookup_way_o;
  logic             ins_valid_i, ins_ready_o, ins_dirty_i;
  logic [TAG_W-1:0] ins_tag_i;
  logic [WAY_W-1:0] ins_way_o;
  logic             evict_valid_o, evict_dirty_o;
  logic [TAG_W-1:0] evict_tag_o;
  logic             inv_valid_i;
  logic [WAY_W-1:0] inv_way_i;
  logic             full_o;
  logic [WAY_W:0]   count_o;

  always #5 clk = ~clk;

  vc_tag_array #(.WAYS(WAYS), .TAG_W(TAG_W)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .lookup_valid_i(lookup_valid_i), .lookup_tag_i(lookup_tag_i),
    .lookup_valid_o(lookup_valid_o), .lookup_hit_o(lookup_hit_o),
    .lookup_way_o(lookup_way_o), .lookup_dirty_o(lookup_dirty_o),
    .ins_valid_i(ins_valid_i), .ins_ready_o(ins_ready_o), .ins_tag_i(ins_tag_i),
    .ins_dirty_i(ins_dirty_i), .ins_way_o(ins_way_o),
    .evict_valid_o(evict_valid_o), .evict_tag_o(evict_tag_o), .evict_dirty_o(evict_dirty_o),
    .inv_valid_i(inv_valid_i), .inv_way_i(inv_way_i),
    .full_o(full_o), .count_o(count_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  bit               m_valid [WAYS];
  bit               m_dirty [WAYS];
  logic [TAG_W-1:0] m_tag   [WAYS];
  int               lru_q[$];   // front = most recently used
  int               fifo_ptr;

  bit               e_lv, e_hit, e_ldirty, e_ev, e_ed;
  int               e_way;
  logic [TAG_W-1:0] e_et;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    lru_q = {};
    for (int w = 0; w < WAYS; w++) begin
      m_valid[w] = 0;
      m_dirty[w] = 0;
      m_tag[w]   = '0;
      lru_q.push_back(w);
    end
    fifo_ptr = 0;
    e_lv = 0; e_hit = 0; e_ldirty = 0; e_ev = 0; e_ed = 0; e_way = 0; e_et = '0;
  endtask

  task automatic touch(input int w);
`ifdef VC_TAG_LRU_EN
    for (int i = 0; i < lru_q.size(); i++) begin
      if (lru_q[i] == w) begin
        lru_q.delete(i);
        break;
      end
    end
    lru_q.push_front(w);
`endif
  endtask

  function automatic int victim();
`ifdef VC_TAG_LRU_EN
    return lru_q[lru_q.size() - 1];
`else
    return fifo_ptr;
`endif
  endfunction

  task automatic clear_inputs();
    lookup_valid_i = 0; lookup_tag_i = '0;
    ins_valid_i = 0; ins_tag_i = '0; ins_dirty_i = 0;
    inv_valid_i = 0; inv_way_i = '0;
  endtask

  // Drives one cycle of stimulus just after a falling edge, checks combinational
  // insert outputs before the rising edge and registered outputs at the next falling edge.
  task automatic step(input bit lv, input logic [TAG_W-1:0] lt, input bit iv,
                      input logic [TAG_W-1:0] it, input bit id, input bit nv, input int nw);
    int w;
    int cnt;
    lookup_valid_i = lv; lookup_tag_i = lt;
    ins_valid_i = iv; ins_tag_i = it; ins_dirty_i = id;
    inv_valid_i = nv; inv_way_i = nw[WAY_W-1:0];

    e_lv = lv; e_hit = 0; e_way = 0; e_ldirty = 0;
    if (lv) begin
      for (int k = 0; k < WAYS; k++) begin
        if (m_valid[k] && m_tag[k] == lt) begin
          e_hit = 1; e_way = k; e_ldirty = m_dirty[k];
        end
      end
    end
    if (e_hit) touch(e_way);
    e_ev = 0; e_et = '0; e_ed = 0; w = -1;
    if (nv) begin
      m_valid[nw] = 0;
      m_dirty[nw] = 0;
    end else if (iv) begin
      for (int k = 0; k < WAYS; k++) if (m_valid[k] && m_tag[k] == it) w = k;
      if (w >= 0) begin
        m_dirty[w] = m_dirty[w] | id;
      end else begin
        for (int k = WAYS - 1; k >= 0; k--) if (!m_valid[k]) w = k;
        if (w < 0) begin
          w = victim();
          e_ev = 1; e_et = m_tag[w]; e_ed = m_dirty[w];
          fifo_ptr = (fifo_ptr + 1) % WAYS;
        end
        m_dirty[w] = id;
      end
      m_valid[w] = 1;
      m_tag[w]   = it;
      touch(w);
    end

    #1;
    check_eq("ins_ready", ins_ready_o, !nv);
    if (iv && !nv) check_eq("ins_way", ins_way_o, w);
    @(negedge clk);
    cnt = 0;
    for (int k = 0; k < WAYS; k++) cnt += m_valid[k];
    check_eq("lookup_valid", lookup_valid_o, e_lv);
    check_eq("lookup_hit", lookup_hit_o, e_hit);
    check_eq("lookup_way", lookup_way_o, e_way);
    check_eq("lookup_dirty", lookup_dirty_o, e_ldirty);
    check_eq("evict_valid", evict_valid_o, e_ev);
    check_eq("evict_tag", evict_tag_o, e_et);
    check_eq("evict_dirty", evict_dirty_o, e_ed);
    check_eq("count", count_o, cnt);
    check_eq("full", full_o, cnt == WAYS);
  endtask

  // Reset with traffic on the inputs; everything pending must be dropped.
  task automatic do_reset();
    rst_i = 1;
    lookup_valid_i = 1; lookup_tag_i = 'h10;
    ins_valid_i = 1; ins_tag_i = 'h99; ins_dirty_i = 1;
    @(negedge clk);
    rst_i = 0;
    clear_inputs();
    model_reset();
    #1;
    check_eq("rst_lookup_valid", lookup_valid_o, 0);
    check_eq("rst_lookup_hit", lookup_hit_o, 0);
    check_eq("rst_lookup_way", lookup_way_o, 0);
    check_eq("rst_lookup_dirty", lookup_dirty_o, 0);
    check_eq("rst_evict_valid", evict_valid_o, 0);
    check_eq("rst_evict_tag", evict_tag_o, 0);
    check_eq("rst_evict_dirty", evict_dirty_o, 0);
    check_eq("rst_ins_ready", ins_ready_o, 1);
    check_eq("rst_ins_way", ins_way_o, 0);
    check_eq("rst_count", count_o, 0);
    check_eq("rst_full", full_o, 0);
  endtask

  task automatic fill();
    for (int t = 'h10; t < 'h18; t++) step(0, '0, 1, TAG_W'(t), 0, 0, 0);
  endtask

  initial begin
    clear_inputs();
    rst_i = 1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    do_reset();

    step(1, 'h5, 0, '0, 0, 0, 0);
    check_eq("first_lookup_miss", lookup_hit_o, 0);
    fill();
    check_eq("full_after_fill", full_o, 1);
    step(1, 'h13, 0, '0, 0, 0, 0);
    check_eq("hit_13_way", lookup_way_o, 3);
    step(0, '0, 1, 'h20, 1, 0, 0);
    check_eq("evict_first_tag", evict_tag_o, 'h10);

    do_reset();
    fill();
    step(1, 'h10, 0, '0, 0, 0, 0);
    step(0, '0, 1, 'h21, 1, 0, 0);
`ifdef VC_TAG_LRU_EN
    check_eq("evict_after_touch", evict_tag_o, 'h11);
`else
    check_eq("evict_after_touch", evict_tag_o, 'h10);
`endif

    do_reset();
    fill();
    step(0, '0, 1, 'h14, 1, 0, 0);
    step(1, 'h14, 0, '0, 0, 0, 0);
    check_eq("dirty_merge", lookup_dirty_o, 1);
    step(0, '0, 1, 'h30, 0, 1, 2);
    check_eq("count_after_inv", count_o, 7);
    step(0, '0, 1, 'h30, 0, 0, 0);
    step(1, 'h15, 0, '0, 0, 1, 5);
    check_eq("hit_during_inv", lookup_hit_o, 1);
    step(1, 'h15, 0, '0, 0, 0, 0);
    check_eq("miss_after_inv", lookup_hit_o, 0);

    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 1), TAG_W'('h40 + $urandom_range(0, 11)),
           $urandom_range(0, 2) != 0, TAG_W'('h40 + $urandom_range(0, 11)),
           $urandom_range(0, 1), $urandom_range(0, 5) == 0, $urandom_range(0, WAYS - 1));
      if (i == 300) do_reset();
    end

    fill();
    step(1, 'h11, 1, 'h77, 1, 0, 0);
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
